synth_frame_aligner: RTL

SYNTH_FRAME_ALIGNER -- requirements
Module: synth_frame_aligner

---
 rtl/synth_frame_aligner_pkg.sv | 23 ++
 rtl/synth_frame_aligner_axis_out_reg.sv | 41 ++++
 rtl/synth_frame_aligner.sv | 132 +++++++++++++
 3 files changed

// File: rtl/synth_frame_aligner_pkg.sv
// Shared definitions for the synthesizer frame aligner: state encoding,
// frame-length bounds and default settings-bus addresses.
package synth_frame_aligner_pkg;

  typedef enum logic [1:0] {
    ST_PASS = 2'd0,
    ST_PAD  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  localparam logic [3:0]  LOG2_MIN         = 4'd3;
  localparam logic [3:0]  LOG2_MAX         = 4'd11;
  localparam int unsigned BIN_W            = 11;
  localparam int unsigned DEF_SR_FRAME_LEN = 129;
  localparam int unsigned DEF_SR_CLR_ERR   = 130;

  function automatic logic [3:0] clamp_log2(input logic [3:0] v);
    if (v < LOG2_MIN)      return LOG2_MIN;
    else if (v > LOG2_MAX) return LOG2_MAX;
    else                   return v;
  endfunction

endpackage

// File: rtl/synth_frame_aligner_axis_out_reg.sv
// Single-entry AXI-stream output register: loads when empty or when the
// held beat is being accepted downstream; holds data stable while stalled.
module axis_out_reg #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  output logic              o_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  input  logic              i_ready
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_last;

  assign o_ready = ~r_valid | i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
        r_last <= i_last;
      end
    end
  end

endmodule

// File: rtl/synth_frame_aligner.sv
// Forces the host bin stream into frames of exactly 2^L bins: short frames are
// zero-padded, long frames truncated with the excess discarded up to tlast.
module synth_frame_aligner
  import synth_frame_aligner_pkg::*;
#(
  parameter int unsigned SR_FRAME_LEN = DEF_SR_FRAME_LEN,
  parameter int unsigned SR_CLR_ERR   = DEF_SR_CLR_ERR,
  parameter int unsigned DEF_LOG2_LEN = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [31:0] s_axis_data_tdata,
  input  logic        s_axis_data_tlast,
  input  logic        s_axis_data_tvalid,
  output logic        s_axis_data_tready,
  output logic [31:0] m_axis_data_tdata,
  output logic        m_axis_data_tlast,
  output logic        m_axis_data_tvalid,
  input  logic        m_axis_data_tready,
  output logic [15:0] err_short_cnt,
  output logic [15:0] err_long_cnt
);

  state_t             r_state;
  logic [BIN_W-1:0]   r_bin_cnt;
  logic [3:0]         r_log2_len;
  logic [3:0]         r_log2_pend;
  logic [15:0]        r_err_short;
  logic [15:0]        r_err_long;

  state_t             w_state_nxt;
  logic [BIN_W-1:0]   w_last_bin;
  logic               w_at_last;
  logic               w_out_ready;
  logic               w_s_ready;
  logic               w_load;
  logic [31:0]        w_load_data;
  logic               w_load_last;
  logic               w_inc_short;
  logic               w_inc_long;
  logic               w_wr_len;
  logic               w_clr;
  logic               w_unused;

  assign w_unused   = ^set_data[31:4];
  assign w_wr_len   = set_stb && (set_addr == 8'(SR_FRAME_LEN));
  assign w_clr      = set_stb && (set_addr == 8'(SR_CLR_ERR));
  // For L = 11 the shift wraps to zero, so subtracting one still gives 2047.
  assign w_last_bin = (BIN_W'(1) << r_log2_len) - BIN_W'(1);
  assign w_at_last  = (r_bin_cnt == w_last_bin);

  assign s_axis_data_tready = w_s_ready & ~reset;
  assign err_short_cnt      = r_err_short;
  assign err_long_cnt       = r_err_long;

  always_comb begin
    w_state_nxt = r_state;
    w_s_ready   = 1'b0;
    w_load      = 1'b0;
    w_load_data = '0;
    w_load_last = 1'b0;
    w_inc_short = 1'b0;
    w_inc_long  = 1'b0;
    unique case (r_state)
      ST_PASS: begin
        w_s_ready   = w_out_ready;
        w_load      = s_axis_data_tvalid & w_out_ready;
        w_load_data = s_axis_data_tdata;
        w_load_last = w_at_last;
        if (w_load) begin
          if (s_axis_data_tlast && !w_at_last) begin
            w_inc_short = 1'b1;
            w_state_nxt = ST_PAD;
          end else if (!s_axis_data_tlast && w_at_last) begin
            w_inc_long  = 1'b1;
            w_state_nxt = ST_DROP;
          end
        end
      end
      ST_PAD: begin
        w_load      = w_out_ready;
        w_load_last = w_at_last;
        if (w_load && w_at_last) w_state_nxt = ST_PASS;
      end
      ST_DROP: begin
        w_s_ready = 1'b1;
        if (s_axis_data_tvalid && s_axis_data_tlast) w_state_nxt = ST_PASS;
      end
      default: w_state_nxt = ST_PASS;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_PASS;
      r_bin_cnt   <= '0;
      r_log2_len  <= 4'(DEF_LOG2_LEN);
      r_log2_pend <= 4'(DEF_LOG2_LEN);
      r_err_short <= '0;
      r_err_long  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_wr_len) r_log2_pend <= clamp_log2(set_data[3:0]);
      // Frame boundary only: a bin-0 beat loading this cycle is never a last bin.
      if (r_state == ST_PASS && r_bin_cnt == '0) r_log2_len <= r_log2_pend;
      if (w_load) r_bin_cnt <= w_at_last ? '0 : r_bin_cnt + BIN_W'(1);
      if (w_clr)                                 r_err_short <= '0;
      else if (w_inc_short && r_err_short != '1) r_err_short <= r_err_short + 16'd1;
      if (w_clr)                                 r_err_long  <= '0;
      else if (w_inc_long && r_err_long != '1)   r_err_long  <= r_err_long + 16'd1;
    end
  end

  axis_out_reg #(
    .DATA_W (32)
  ) u_out_reg (
    .clk     (clk),
    .rst     (reset),
    .i_valid (w_load),
    .i_data  (w_load_data),
    .i_last  (w_load_last),
    .o_ready (w_out_ready),
    .o_valid (m_axis_data_tvalid),
    .o_data  (m_axis_data_tdata),
    .o_last  (m_axis_data_tlast),
    .i_ready (m_axis_data_tready)
  );

endmodule
